// File: rtl/crossbar_config.sv
// crossbar_config: shadow/live input-select table for the trigger crossbar.
// A commit copies shadow to live once trig_out_mon is quiet, or on timeout.
// Ports:
//   wr_en/wr_addr/wr_data  shadow write; wr_err pulses on bad addr/data
//   rd_en/rd_addr/rd_shadow -> rd_valid/rd_data  table readback (1 cycle)
//   commit -> busy, commit_done, commit_forced  apply handshake
//   trig_out_mon  crossbar outputs, watched for the quiet window
//   muxsel_flat   live table, entry i at [i*SEL_BITS +: SEL_BITS]
// Build option: CROSSBAR_CONFIG_READBACK_EN enables the rd_* path;
// without it rd_valid and rd_data are tied low.
module crossbar_config #(
  parameter int NUM_PORTS      = 12,
  parameter int SEL_BITS       = 4,
  parameter int QUIET_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [3:0]                    wr_addr,
  input  logic [SEL_BITS-1:0]           wr_data,
  output logic                          wr_err,
  input  logic                          rd_en,
  input  logic [3:0]                    rd_addr,
  input  logic                          rd_shadow,
  output logic                          rd_valid,
  output logic [SEL_BITS-1:0]           rd_data,
  input  logic                          commit,
  output logic                          busy,
  output logic                          commit_done,
  output logic                          commit_forced,
  input  logic [NUM_PORTS-1:0]          trig_out_mon,
  output logic [NUM_PORTS*SEL_BITS-1:0] muxsel_flat
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [QW-1:0] QMAX = QW'(QUIET_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    APPLY
  } state_t;

  state_t              state;
  logic [QW-1:0]       qcnt;
  logic [TW-1:0]       tcnt;
  logic [SEL_BITS-1:0] shadow [NUM_PORTS];
  logic [SEL_BITS-1:0] live   [NUM_PORTS];

  logic wr_ok;
  logic mon_quiet;
  logic quiet_hit;
  logic tmo_hit;

  assign wr_ok = wr_en
              && (32'(wr_addr) < NUM_PORTS)
              && (32'(wr_data) < NUM_PORTS);

  assign mon_quiet = (trig_out_mon == '0);
  assign quiet_hit = mon_quiet && (qcnt == QMAX);
  assign tmo_hit   = (tcnt == TMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++)
        shadow[i] <= SEL_BITS'(i);
      wr_err <= 1'b0;
    end else begin
      if (wr_ok)
        shadow[wr_addr] <= wr_data;
      wr_err <= wr_en && !wr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      qcnt          <= '0;
      tcnt          <= '0;
      busy          <= 1'b0;
      commit_done   <= 1'b0;
      commit_forced <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++)
        live[i] <= SEL_BITS'(i);
    end else begin
      commit_done   <= 1'b0;
      commit_forced <= 1'b0;
      unique case (state)
        IDLE: begin
          if (commit) begin
            state <= PENDING;
            qcnt  <= '0;
            tcnt  <= '0;
            busy  <= 1'b1;
          end
        end
        PENDING: begin
          if (!mon_quiet)
            qcnt <= '0;
          else if (qcnt != QMAX)
            qcnt <= qcnt + 1'b1;
          if (tcnt != TMAX)
            tcnt <= tcnt + 1'b1;
          // Quiet apply wins when both limits land together.
          if (quiet_hit || tmo_hit) begin
            state         <= APPLY;
            commit_done   <= 1'b1;
            commit_forced <= !quiet_hit;
          end
        end
        APPLY: begin
          for (int i = 0; i < NUM_PORTS; i++)
            live[i] <= shadow[i];
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    muxsel_flat = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      muxsel_flat[i*SEL_BITS +: SEL_BITS] = live[i];
  end

`ifdef CROSSBAR_CONFIG_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (32'(rd_addr) >= NUM_PORTS)
          rd_data <= '0;
        else if (rd_shadow)
          rd_data <= shadow[rd_addr];
        else
          rd_data <= live[rd_addr];
      end
    end
  end
`else
  logic rd_unused;
  assign rd_unused = ^{rd_en, rd_addr, rd_shadow};
  assign rd_valid  = 1'b0;
  assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_crossbar_config.sv
// tb_crossbar_config: scoreboard bench for crossbar_config.
// Reads and commits queue expectations; a negedge monitor retires them.
module tb_crossbar_config;

  localparam int NP = 12;
  localparam int SB = 4;
  localparam int QC = 16;
  localparam int TC = 100;

  logic               clk;
  logic               rst;
  logic               wr_en;
  logic [3:0]         wr_addr;
  logic [SB-1:0]      wr_data;
  logic               wr_err;
  logic               rd_en;
  logic [3:0]         rd_addr;
  logic               rd_shadow;
  logic               rd_valid;
  logic [SB-1:0]      rd_data;
  logic               commit;
  logic               busy;
  logic               commit_done;
  logic               commit_forced;
  logic [NP-1:0]      trig_out_mon;
  logic [NP*SB-1:0]   muxsel_flat;

  crossbar_config #(
    .NUM_PORTS     (NP),
    .SEL_BITS      (SB),
    .QUIET_CYCLES  (QC),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_shadow    (rd_shadow),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .commit       (commit),
    .busy         (busy),
    .commit_done  (commit_done),
    .commit_forced(commit_forced),
    .trig_out_mon (trig_out_mon),
    .muxsel_flat  (muxsel_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic forced;
    int   lat;
    int   start;
  } cm_t;

  cm_t           cm_q [$];
  logic [SB-1:0] rd_q [$];
  logic [SB-1:0] sh_m [NP];
  logic [SB-1:0] lv_m [NP];
  logic          flat_chk = 1'b0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NP*SB-1:0] flat_m();
    logic [NP*SB-1:0] f;
    f = '0;
    for (int i = 0; i < NP; i++)
      f[i*SB +: SB] = lv_m[i];
    return f;
  endfunction

  task automatic models_identity();
    for (int i = 0; i < NP; i++) begin
      sh_m[i] = SB'(i);
      lv_m[i] = SB'(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: retire commit and read expectations as the DUT reports them.
  initial begin
    cm_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        flat_chk = 1'b0;
      end else begin
        if (flat_chk) begin
          check("flat_apply", muxsel_flat, flat_m());
          flat_chk = 1'b0;
        end
        if (commit_done) begin
          if (cm_q.size() == 0) begin
            check("spur_done", commit_done, 1'b0);
          end else begin
            e = cm_q.pop_front();
            check("forced", commit_forced, e.forced);
            check("done_lat", cyc - e.start, e.lat);
            for (int i = 0; i < NP; i++)
              lv_m[i] = sh_m[i];
            flat_chk = 1'b1;
          end
        end else if (commit_forced) begin
          check("forced_alone", commit_forced, 1'b0);
        end
        if (rd_valid) begin
          if (rd_q.size() == 0)
            check("spur_rd", rd_valid, 1'b0);
          else
            check("rd_data", rd_data, rd_q.pop_front());
        end
      end
    end
  end

  task automatic wr(input int a, input int d);
    bit ok;
    ok = (a < NP) && (d < NP);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = SB'(d);
    tick();
    wr_en = 1'b0;
    check($sformatf("wr_err_%0d_%0d", a, d), wr_err, !ok);
    if (ok)
      sh_m[a] = SB'(d);
  endtask

`ifdef CROSSBAR_CONFIG_READBACK_EN
  task automatic rd(input int a, input bit sh);
    logic [SB-1:0] e;
    e = '0;
    if (a < NP)
      e = sh ? sh_m[a] : lv_m[a];
    rd_q.push_back(e);
    rd_en     = 1'b1;
    rd_addr   = 4'(a);
    rd_shadow = sh;
    tick();
    rd_en = 1'b0;
    check("rd_valid", rd_valid, 1'b1);
  endtask
`else
  task automatic rd(input int a, input bit sh);
    rd_en     = 1'b1;
    rd_addr   = 4'(a);
    rd_shadow = sh;
    tick();
    rd_en = 1'b0;
    check("rd_valid_off", rd_valid, 1'b0);
    check("rd_data_off", rd_data, '0);
  endtask
`endif

  task automatic do_commit(input logic forced, input int lat);
    cm_t e;
    e.forced = forced;
    e.lat    = lat;
    e.start  = cyc;
    cm_q.push_back(e);
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while ((cm_q.size() != 0 || busy) && n < lim) begin
      tick();
      n++;
    end
    check("settle_busy", busy, 1'b0);
    check("settle_q", cm_q.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SB-1:0] e5;
    models_identity();
    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    rd_shadow    = 1'b0;
    commit       = 1'b0;
    trig_out_mon = '0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_busy", busy, 1'b0);
    check("rst_done", commit_done, 1'b0);
    check("rst_forced", commit_forced, 1'b0);
    check("rst_wr_err", wr_err, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, '0);
    check("rst_flat", muxsel_flat, flat_m());

    for (int i = 0; i < NP; i++)
      rd(i, 1'b0);
    rd(13, 1'b0);
    tick();

    // Quiet apply of a single entry.
    wr(3, 7);
    rd(3, 1'b1);
    rd(3, 1'b0);
    do_commit(1'b0, QC + 1);
    wait_done(60);
    rd(3, 1'b0);

    // Rejected writes leave the shadow alone.
    wr(12, 0);
    wr(2, 13);
    wr(15, 15);
    rd(2, 1'b1);
    tick();
    check("err_clear", wr_err, 1'b0);

    // Same-cycle shadow read and write return the old value.
`ifdef CROSSBAR_CONFIG_READBACK_EN
    e5 = sh_m[5];
    rd_q.push_back(e5);
    rd_en = 1'b1;
    rd_addr = 4'd5;
    rd_shadow = 1'b1;
`endif
    wr(5, 2);
    rd_en = 1'b0;
    rd(5, 1'b1);

    // Forced apply: outputs never go quiet.
    wr(0, 11);
    trig_out_mon = 12'h001;
    do_commit(1'b1, TC + 1);
    repeat (50) tick();
    check("busy_mid", busy, 1'b1);
    wait_done(200);
    trig_out_mon = '0;

    // Quiet window restart, extra commit and write during pending.
    do_commit(1'b0, 11 + QC + 1);
    repeat (3) tick();
    wr(8, 1);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (5) tick();
    check("pend_busy", busy, 1'b1);
    trig_out_mon = 12'h800;
    tick();
    trig_out_mon = '0;
    wait_done(80);
    repeat (25) tick();

    // Reset in the middle of a pending apply.
    wr(6, 4);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat (5) tick();
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    models_identity();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_flat", muxsel_flat, flat_m());
    repeat (30) tick();
    rd(6, 1'b1);
    do_commit(1'b0, QC + 1);
    wait_done(60);
    check("post_rst_flat", muxsel_flat, flat_m());

    tick();
    check("rd_q_left", rd_q.size(), 0);
    check("cm_q_left", cm_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/crossbar_config.md
Name: crossbar_config

Overview:
- Management-side writer for the trigger crossbar's per-output input selections.
- Holds a shadow selection table written from the management bus. Presents the live table to the crossbar matrix as one flattened vector.
- Applies shadow to live atomically on commit, deferred until the crossbar outputs are quiet so no runt pulse is generated. Forced apply on timeout.
- Sits between the management register bridge and the combinatorial crossbar matrix.

Parameters:
- NUM_PORTS, 12, number of crossbar inputs and outputs.
- SEL_BITS, 4, width of one selection entry (matches muxsel_t).
- QUIET_CYCLES, 16, consecutive all-low output cycles required before apply.
- TIMEOUT_CYCLES, 65535, maximum cycles in PENDING before a forced apply.

Ports:
- clk  input  1  management/crossbar clock
- rst  input  1  synchronous active-high reset
- wr_en  input  1  shadow write strobe
- wr_addr  input  4  output index to write
- wr_data  input  SEL_BITS  selected input index
- wr_err  output  1  one-cycle pulse: write rejected
- rd_en  input  1  read strobe
- rd_addr  input  4  output index to read
- rd_shadow  input  1  1 = read shadow table, 0 = read live table
- rd_valid  output  1  read data valid
- rd_data  output  SEL_BITS  read data
- commit  input  1  request shadow-to-live apply
- busy  output  1  apply pending
- commit_done  output  1  one-cycle pulse on apply
- commit_forced  output  1  one-cycle pulse, concurrent with commit_done, when apply was caused by timeout
- trig_out_mon  input  NUM_PORTS  crossbar outputs, fed back for the quiet check
- muxsel_flat  output  NUM_PORTS*SEL_BITS  live table; entry i occupies bits [i*SEL_BITS +: SEL_BITS]

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - shadow[i] = live[i] = i (identity mapping).
  - FSM enters IDLE; quiet and timeout counters cleared.
  - busy, rd_valid, wr_err, commit_done and commit_forced all 0; rd_data 0.
- Writes:
  - wr_en with wr_addr < NUM_PORTS and wr_data < NUM_PORTS: shadow[wr_addr] updated next cycle. Accepted in any FSM state.
  - Otherwise no update, and wr_err pulses high 1 cycle later.
- Reads:
  - 1-cycle latency: rd_valid and rd_data registered the cycle after rd_en.
  - Out-of-range rd_addr returns 0 with rd_valid = 1.
  - A read of the shadow table in the same cycle as a write to the same address returns the old value.
- FSM states:
  - IDLE: commit -> PENDING; quiet counter and timeout counter cleared.
  - PENDING:
    - busy = 1.
    - Quiet counter increments while trig_out_mon == 0 and clears on any nonzero cycle.
    - Timeout counter increments every cycle.
    - Quiet counter reaching QUIET_CYCLES-1 with trig_out_mon still 0 -> APPLY (normal).
    - Otherwise, timeout counter reaching TIMEOUT_CYCLES-1 -> APPLY (forced).
    - Both conditions in the same cycle: normal apply.
  - APPLY (one cycle):
    - live <= shadow, all entries simultaneously, using shadow values including any write in that same cycle's register state (not the cycle's wr_en).
    - commit_done pulses; commit_forced pulses if the apply was forced.
    - busy = 1 in this cycle; next state IDLE.
- Commit asserted while in PENDING or APPLY is ignored; no queueing. Writes made during PENDING are included in the apply.
- muxsel_flat is registered and changes only in the cycle following APPLY, or at reset.
- Reset mid-PENDING: abandons the apply. Live and shadow return to identity; no commit_done pulse.
- Counters saturate and never wrap.

Optional Feature:
- Macro: CROSSBAR_CONFIG_READBACK_EN.
- Defined: rd_* ports are functional as described above.
- Undefined:
  - Read logic removed; rd_valid tied 0 and rd_data tied 0.
  - Ports remain present, so the instantiation is unchanged.

Test Plan:
- Reset, then read live 0..11 -> rd_data = 0..11, rd_valid one cycle after each rd_en; muxsel_flat = identity.
- Write addr 3 data 7, then commit with trig_out_mon = 0 -> commit_done exactly QUIET_CYCLES+1 cycles after commit; live[3] = 7; commit_forced = 0.
- Write addr 12 data 0, and separately addr 2 data 13 -> wr_err pulse for each; shadow unchanged.
- Hold trig_out_mon = 12'h001 after commit, with TIMEOUT_CYCLES = 100 -> busy for 100 cycles, then commit_done and commit_forced pulse together; live updated.
- Commit; at quiet count 10 pulse trig_out_mon for one cycle -> quiet counter restarts; apply occurs QUIET_CYCLES cycles after the pulse ends. A second commit during PENDING produces no extra commit_done.
- Assert rst mid-PENDING -> busy = 0 next cycle; no commit_done; muxsel_flat = identity.
